ldm_stm_seq: RTL
================

# ldm_stm_seq

Multi-cycle sequencer for Thumb block transfers (PUSH, POP, LDMIA, STMIA) on the data-memory port of the MEM stage. On a START pulse from EXE it walks a 9-bit register list and issues one 32-bit DMEM access per listed register in ascending address order. It produces register-file writebacks for loads, an optional base-register writeback, and a stall to the hazard unit until the sequence completes. Single-transfer LDR/STR traffic does not pass through this block.

## Interface
Parameters: none.
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle command pulse from EXE; sampled only in IDLE
- LDST  in  1  1: load (POP/LDMIA), 0: store (PUSH/STMIA)
- REG_LIST  in  9  bits 7:0 map to R0..R7; bit 8 maps to R14 on store, R15 on load
- BASE  in  32  base address value; bits 1:0 ignored
- BASE_A  in  4  base register index, used for writeback
- DECR  in  1  1: full-descending (PUSH), start address = BASE − 4·count
- WBACK  in  1  1: write the final base back to BASE_A
- RF_RA  out  4  register-file read index for store data
- RF_RD  in  32  register-file read data for RF_RA, combinational
- REQ  out  1  DMEM request
- DRW  out  1  1: read, 0: write
- DADDR  out  32  word address, bits 1:0 always 00
- DSIZE  out  2  always 2'b11 while REQ
- DOUT  out  32  store data; equals RF_RD while REQ and not DRW
- DRDY  in  1  DMEM ready; a transfer completes on an edge where REQ and DRDY are both high
- DIN  in  32  load data, valid when DRDY is high
- WB_A  out  4  writeback register index
- W_VALID  out  1  writeback strobe
- WB_D  out  32  writeback data
- STALL  out  1  freeze the pipeline upstream of MEM
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, FIN.
  - IDLE→XFER on START with a non-empty list.
  - IDLE→FIN on START with an empty list.
  - XFER→FIN when the last listed register completes.
  - FIN→IDLE unconditionally.
- On START, latch LDST, list, BASE_A, WBACK and DECR. Compute count = popcount(REG_LIST) (0..9).
  - Start address = BASE[31:2]·4 when DECR=0, or that minus 4·count when DECR=1.
  - Final base = start + 4·count when DECR=0, or start when DECR=1.
  - All address arithmetic is modulo 2^32.
- XFER: the current register is the lowest set bit of the remaining list.
  - REQ=1; DRW=LDST; RF_RA=current register index; DADDR=current address.
  - On REQ&DRDY: clear that bit and add 4 to the address.
- Load writeback: W_VALID = REQ&DRDY&LDST, WB_A = current register index, WB_D = DIN. This is combinational in the completing cycle.
- FIN: DONE=1.
  - If WBACK is set, drive W_VALID=1, WB_A=BASE_A, WB_D=final base.
  - Exception: on a load whose list contains BASE_A, base writeback is suppressed and the loaded value stands.
- STALL = (IDLE & START) | XFER. STALL is low in FIN, so the pipeline advances on that cycle.
- START outside IDLE is ignored.
- Reset value of every output is 0 (DADDR, DOUT and WB_D all zero). Assertion of RST_N mid-sequence aborts the sequence immediately: state goes to IDLE and any pending transfer is dropped.

## Timing
- START in cycle 0. The first REQ is in cycle 1, registered.
- With DRDY held high, transfer k occurs in cycle k, and DONE/FIN is in cycle count+1.
- An empty list gives DONE in cycle 1 with no REQ.
- Each DRDY-low cycle extends XFER by one cycle. During a wait, REQ, DRW, DADDR and RF_RA are held stable, and DOUT is held provided RF_RD is stable.
- A new START is accepted no earlier than the cycle after FIN.

## Structure
- Shared package arm9_mem_pkg holds:
  - the state enum
  - DSIZE_WORD = 2'b11
  - REG_LR = 4'd14 and REG_PC = 4'd15
- Sub-module reglist_penc: a 9-bit lowest-set-bit priority encoder producing a 4-bit register index and a valid flag. It takes LDST as an input for the bit-8 mapping.
- Popcount and the address adder live in the top level.

## Test plan
- PUSH {R0,R2,LR}, list=9'h105, BASE=0x1000, DECR=1, WBACK=1, BASE_A=13, DRDY=1 → stores to 0xFF4/0xFF8/0xFFC with RF_RA=0/2/14 in cycles 1–3; cycle 4 has DONE, W_VALID, WB_A=13, WB_D=0xFF4.
- POP {R1,PC}, list=9'h102, LDST=1, BASE=0xFF4, WBACK=1 → reads 0xFF4 written to R1 and 0xFF8 written to R15 with WB_D=DIN; FIN writes R13=0xFFC.
- LDMIA R0!,{R3} with DRDY low for cycles 1–2 → REQ and DADDR stable for 3 cycles; W_VALID only in cycle 3; DONE in cycle 4 with R0 written as BASE+4.
- LDMIA R2!,{R2,R4}, BASE=0x200 → R2 and R4 loaded from 0x200 and 0x204; no base writeback in FIN.
- Empty list START → no REQ, STALL high in cycle 0 only, DONE in cycle 1, W_VALID=0.
- STMIA with BASE=0xFFFFFFFC and 2 registers → addresses 0xFFFFFFFC then 0x00000000. Second run: drop RST_N after the first transfer → all outputs 0 immediately; the next START runs normally.

Source files
------------

// File: rtl/arm9_mem_pkg.sv
// Shared definitions for the MEM-stage block-transfer sequencer.
package arm9_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FIN = 2'd2} seq_state_e;

  localparam logic [1:0] DSIZE_WORD = 2'b11;
  localparam logic [3:0] REG_LR     = 4'd14;
  localparam logic [3:0] REG_PC     = 4'd15;

  // True when register r is named by list l; bit 8 is LR for stores, PC for loads.
  function automatic logic reg_in_list(input logic [8:0] l, input logic ld, input logic [3:0] r);
    logic hit;
    if (r[3]) hit = l[8] && (r == (ld ? REG_PC : REG_LR));
    else      hit = l[r[2:0]];
    return hit;
  endfunction
endpackage

// File: rtl/ldm_stm_seq_if.sv
// Command, DMEM, register-file and hazard signals of the block-transfer sequencer.
interface ldm_stm_seq_if;
  logic        start, ldst, decr, wback;
  logic [8:0]  reg_list;
  logic [31:0] base;
  logic [3:0]  base_a;
  logic [3:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        req, drw, drdy;
  logic [31:0] daddr, dout, din;
  logic [1:0]  dsize;
  logic [3:0]  wb_a;
  logic        w_valid;
  logic [31:0] wb_d;
  logic        stall, done;

  modport master (
    input  start, ldst, decr, wback, reg_list, base, base_a, rf_rd, drdy, din,
    output rf_ra, req, drw, daddr, dsize, dout, wb_a, w_valid, wb_d, stall, done
  );
  modport slave (
    output start, ldst, decr, wback, reg_list, base, base_a, rf_rd, drdy, din,
    input  rf_ra, req, drw, daddr, dsize, dout, wb_a, w_valid, wb_d, stall, done
  );
endinterface

// File: rtl/reglist_penc.sv
// Lowest-set-bit encoder for a 9-bit Thumb register list.
module reglist_penc
  import arm9_mem_pkg::*;
(
  input  logic [8:0] list_i,
  input  logic       ldst_i,
  output logic [3:0] idx_o,
  output logic       vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = |list_i;
    // Descending scan so the lowest set bit wins.
    for (int i = 8; i >= 0; i--) begin
      if (list_i[i]) idx_o = (i == 8) ? (ldst_i ? REG_PC : REG_LR) : 4'(i);
    end
  end
endmodule

// File: rtl/ldm_stm_seq.sv
// PUSH/POP/LDMIA/STMIA sequencer: one word access per listed register, ascending addresses.
module ldm_stm_seq
  import arm9_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ldm_stm_seq_if.master bus
);
  seq_state_e  state_q;
  logic [8:0]  list_q;
  logic [31:0] addr_q, final_q;
  logic        ldst_q, keep_q;
  logic [3:0]  basea_q;

  logic [3:0]  cnt, cur_idx;
  logic        cur_vld;
  logic [31:0] base_al, cnt4, start_d, final_d;
  logic [8:0]  list_nxt;
  logic        in_xfer, in_fin, ld_wb;

  reglist_penc u_penc (.list_i(list_q), .ldst_i(ldst_q), .idx_o(cur_idx), .vld_o(cur_vld));

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + {3'b000, bus.reg_list[i]};
  end

  assign base_al  = {bus.base[31:2], 2'b00};
  assign cnt4     = {26'd0, cnt, 2'b00};
  assign start_d  = bus.decr ? base_al - cnt4 : base_al;
  assign final_d  = bus.decr ? start_d : base_al + cnt4;
  assign list_nxt = list_q & (list_q - 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      final_q <= '0;
      ldst_q  <= 1'b0;
      keep_q  <= 1'b0;
      basea_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          list_q  <= bus.reg_list;
          addr_q  <= start_d;
          final_q <= final_d;
          ldst_q  <= bus.ldst;
          basea_q <= bus.base_a;
          // A load that reloads the base register keeps the loaded value.
          keep_q  <= bus.wback & ~(bus.ldst & reg_in_list(bus.reg_list, bus.ldst, bus.base_a));
          state_q <= (|bus.reg_list) ? XFER : FIN;
        end
        XFER: if (bus.drdy) begin
          list_q  <= list_nxt;
          addr_q  <= addr_q + 32'd4;
          if (list_nxt == '0) state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_xfer = (state_q == XFER);
  assign in_fin  = (state_q == FIN);
  assign ld_wb   = bus.req & bus.drdy & ldst_q;

  assign bus.req     = in_xfer & cur_vld;
  assign bus.drw     = bus.req & ldst_q;
  assign bus.rf_ra   = bus.req ? cur_idx : 4'd0;
  assign bus.daddr   = bus.req ? addr_q : 32'd0;
  assign bus.dsize   = bus.req ? DSIZE_WORD : 2'b00;
  assign bus.dout    = (bus.req & ~ldst_q) ? bus.rf_rd : 32'd0;
  assign bus.w_valid = ld_wb | (in_fin & keep_q);
  assign bus.wb_a    = ld_wb ? cur_idx : ((in_fin & keep_q) ? basea_q : 4'd0);
  assign bus.wb_d    = ld_wb ? bus.din : ((in_fin & keep_q) ? final_q : 32'd0);
  assign bus.stall   = ((state_q == IDLE) & bus.start) | in_xfer;
  assign bus.done    = in_fin;
endmodule
